// File: rtl/alu_op_decoder.sv
// Decode stage: RV32I (+ optional Zbb ANDN) instruction word to ALU op, operand selects,
// immediate and register fields, registered behind a valid/ready pipeline slot.
module alu_op_decoder #(
  parameter int unsigned XLEN       = 32,
  parameter bit          ENABLE_ZBB = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_op,
  output logic            out_lhs_pc,
  output logic            out_rhs_imm,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  localparam logic [3:0] ALU_OP_ADD  = 4'b0000;
  localparam logic [3:0] ALU_OP_SLL  = 4'b0001;
  localparam logic [3:0] ALU_OP_SLT  = 4'b0010;
  localparam logic [3:0] ALU_OP_SLTU = 4'b0011;
  localparam logic [3:0] ALU_OP_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OP_SUB  = 4'b1000;
  localparam logic [3:0] ALU_OP_RHS  = 4'b1010;
  localparam logic [3:0] ALU_OP_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OP_ANDN = 4'b1111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd_field;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_shamt;

  logic [3:0]  dec_op;
  logic        dec_lhs_pc;
  logic        dec_rhs_imm;
  logic [31:0] dec_imm32;
  logic        dec_writes_rd;
  logic        dec_illegal;
  logic        dec_rd_we;
  logic        accept;

  assign opcode   = in_inst[6:0];
  assign f3       = in_inst[14:12];
  assign f7       = in_inst[31:25];
  assign rd_field = in_inst[11:7];

  assign imm_i     = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s     = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b     = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                      in_inst[11:8], 1'b0};
  assign imm_u     = {in_inst[31:12], 12'b0};
  assign imm_j     = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                      in_inst[30:21], 1'b0};
  assign imm_shamt = {27'b0, in_inst[24:20]};

  always_comb begin
    dec_op        = ALU_OP_ADD;
    dec_lhs_pc    = 1'b0;
    dec_rhs_imm   = 1'b0;
    dec_imm32     = '0;
    dec_writes_rd = 1'b0;
    dec_illegal   = 1'b0;

    if (in_inst[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end else begin
      case (opcode)
        OPC_OP: begin
          dec_writes_rd = 1'b1;
          if (f7 == F7_ZERO) begin
            dec_op = {1'b0, f3};
          end else if (f7 == F7_ALT) begin
            case (f3)
              3'b000:  dec_op = ALU_OP_SUB;
              3'b101:  dec_op = ALU_OP_SRA;
              3'b111: begin
                if (ENABLE_ZBB) dec_op      = ALU_OP_ANDN;
                else            dec_illegal = 1'b1;
              end
              default: dec_illegal = 1'b1;
            endcase
          end else begin
            dec_illegal = 1'b1;
          end
        end
        OPC_OP_IMM: begin
          dec_writes_rd = 1'b1;
          dec_rhs_imm   = 1'b1;
          dec_imm32     = imm_i;
          dec_op        = {1'b0, f3};
          // Shifts carry a 5-bit shamt; the funct7 bits are opcode, not immediate.
          if (f3 == 3'b001) begin
            dec_imm32 = imm_shamt;
            if (f7 != F7_ZERO) dec_illegal = 1'b1;
          end else if (f3 == 3'b101) begin
            dec_imm32 = imm_shamt;
            if (f7 == F7_ALT)       dec_op      = ALU_OP_SRA;
            else if (f7 != F7_ZERO) dec_illegal = 1'b1;
          end
        end
        OPC_LUI: begin
          dec_op        = ALU_OP_RHS;
          dec_rhs_imm   = 1'b1;
          dec_imm32     = imm_u;
          dec_writes_rd = 1'b1;
        end
        OPC_AUIPC: begin
          dec_lhs_pc    = 1'b1;
          dec_rhs_imm   = 1'b1;
          dec_imm32     = imm_u;
          dec_writes_rd = 1'b1;
        end
        OPC_JAL: begin
          dec_lhs_pc    = 1'b1;
          dec_rhs_imm   = 1'b1;
          dec_imm32     = imm_j;
          dec_writes_rd = 1'b1;
        end
        OPC_JALR: begin
          dec_rhs_imm   = 1'b1;
          dec_imm32     = imm_i;
          dec_writes_rd = 1'b1;
          if (f3 != 3'b000) dec_illegal = 1'b1;
        end
        OPC_LOAD: begin
          dec_rhs_imm   = 1'b1;
          dec_imm32     = imm_i;
          dec_writes_rd = 1'b1;
        end
        OPC_STORE: begin
          dec_rhs_imm = 1'b1;
          dec_imm32   = imm_s;
        end
        OPC_BRANCH: begin
          dec_imm32 = imm_b;
          case (f3)
            3'b000, 3'b001: dec_op      = ALU_OP_SUB;
            3'b100, 3'b101: dec_op      = ALU_OP_SLT;
            3'b110, 3'b111: dec_op      = ALU_OP_SLTU;
            default:        dec_illegal = 1'b1;
          endcase
        end
        default: dec_illegal = 1'b1;
      endcase
    end

    if (dec_illegal) dec_op = ALU_OP_ADD;
  end

  assign dec_rd_we = dec_writes_rd && !dec_illegal && (rd_field != 5'd0);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_alu_op  <= ALU_OP_ADD;
      out_lhs_pc  <= 1'b0;
      out_rhs_imm <= 1'b0;
      out_imm     <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
      out_pc      <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_alu_op  <= dec_op;
      out_lhs_pc  <= dec_lhs_pc;
      out_rhs_imm <= dec_rhs_imm;
      out_imm     <= XLEN'($signed(dec_imm32));
      out_rs1     <= in_inst[19:15];
      out_rs2     <= in_inst[24:20];
      out_rd      <= rd_field;
      out_rd_we   <= dec_rd_we;
      out_pc      <= in_pc;
      out_illegal <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed bench for alu_op_decoder: table of instruction vectors plus handshake,
// stall, flush and reset sequences; a second instance checks the ENABLE_ZBB=0 build.
module tb_alu_op_decoder;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;

  logic        in_ready, out_valid, out_lhs_pc, out_rhs_imm, out_rd_we, out_illegal;
  logic [3:0]  out_alu_op;
  logic [31:0] out_imm, out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd;

  logic        z_in_ready, z_out_valid, z_out_lhs_pc, z_out_rhs_imm, z_out_rd_we, z_out_illegal;
  logic [3:0]  z_out_alu_op;
  logic [31:0] z_out_imm, z_out_pc;
  logic [4:0]  z_out_rs1, z_out_rs2, z_out_rd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_op_decoder #(.XLEN(32), .ENABLE_ZBB(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_lhs_pc(out_lhs_pc), .out_rhs_imm(out_rhs_imm),
    .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  alu_op_decoder #(.XLEN(32), .ENABLE_ZBB(1'b0)) dut_nozbb (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(z_out_valid), .out_ready(out_ready),
    .out_alu_op(z_out_alu_op), .out_lhs_pc(z_out_lhs_pc), .out_rhs_imm(z_out_rhs_imm),
    .out_imm(z_out_imm), .out_rs1(z_out_rs1), .out_rs2(z_out_rs2), .out_rd(z_out_rd),
    .out_rd_we(z_out_rd_we), .out_pc(z_out_pc), .out_illegal(z_out_illegal)
  );

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [3:0]  op;
    logic        illegal;
    logic        rd_we;
    logic        lhs_pc;
    logic        rhs_imm;
    logic [31:0] imm;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string n, input logic [31:0] inst, input logic [3:0] op,
                         input logic ill, input logic we, input logic lpc, input logic rimm,
                         input logic [31:0] imm, input logic [4:0] rd);
    vec_t v;
    v.name = n; v.inst = inst; v.op = op; v.illegal = ill; v.rd_we = we;
    v.lhs_pc = lpc; v.rhs_imm = rimm; v.imm = imm; v.rd = rd;
    vecs.push_back(v);
  endtask

  // Present one instruction with out_ready=1 and sample the registered result.
  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    @(negedge clk);
    in_valid = 1'b1; in_inst = inst; in_pc = pc; out_ready = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] seq[4];
    logic [3:0]  seq_op[4];

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = 32'h0; in_pc = 32'h0;

    //        name        inst          op     ill we lpc rimm imm           rd
    add_vec("add",     32'h003100B3, 4'h0, 0, 1, 0, 0, 32'h0,        5'd1);
    add_vec("sub",     32'h40B50533, 4'h8, 0, 1, 0, 0, 32'h0,        5'd10);
    add_vec("srai",    32'h40335293, 4'hD, 0, 1, 0, 1, 32'h3,        5'd5);
    add_vec("lui",     32'h123450B7, 4'hA, 0, 1, 0, 1, 32'h12345000, 5'd1);
    add_vec("andn",    32'h403170B3, 4'hF, 0, 1, 0, 0, 32'h0,        5'd1);
    add_vec("zero",    32'h00000000, 4'h0, 1, 0, 0, 0, 32'h0,        5'd0);
    add_vec("ones7f",  32'h0000007F, 4'h0, 1, 0, 0, 0, 32'h0,        5'd0);
    add_vec("add_x0",  32'h00310033, 4'h0, 0, 0, 0, 0, 32'h0,        5'd0);
    add_vec("addi_m1", 32'hFFF10093, 4'h0, 0, 1, 0, 1, 32'hFFFFFFFF, 5'd1);
    add_vec("auipc",   32'h00001097, 4'h0, 0, 1, 1, 1, 32'h00001000, 5'd1);
    add_vec("beq",     32'h00208463, 4'h8, 0, 0, 0, 0, 32'h8,        5'd8);
    add_vec("bltu",    32'h0020E463, 4'h3, 0, 0, 0, 0, 32'h8,        5'd8);
    add_vec("br_f3_2", 32'h0020A463, 4'h0, 1, 0, 0, 0, 32'h8,        5'd8);
    add_vec("sw",      32'h0020A223, 4'h0, 0, 0, 0, 1, 32'h4,        5'd4);
    add_vec("jal",     32'h010000EF, 4'h0, 0, 1, 1, 1, 32'h10,       5'd1);
    add_vec("slli_f7", 32'h40311093, 4'h0, 1, 0, 0, 1, 32'h3,        5'd1);
    add_vec("mul",     32'h023100B3, 4'h0, 1, 0, 0, 0, 32'h0,        5'd1);
    add_vec("sltiu",   32'h00513093, 4'h3, 0, 1, 0, 1, 32'h5,        5'd1);
    add_vec("jalr_f3", 32'h000110E7, 4'h0, 1, 0, 0, 1, 32'h0,        5'd1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_op", 32'(out_alu_op), 32'd0);
    chk("reset_imm", out_imm, 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].inst, 32'h1000 + 32'(i) * 4);
      chk({vecs[i].name, ".valid"},   32'(out_valid),   32'd1);
      chk({vecs[i].name, ".op"},      32'(out_alu_op),  32'(vecs[i].op));
      chk({vecs[i].name, ".illegal"}, 32'(out_illegal), 32'(vecs[i].illegal));
      chk({vecs[i].name, ".rd_we"},   32'(out_rd_we),   32'(vecs[i].rd_we));
      chk({vecs[i].name, ".rd"},      32'(out_rd),      32'(vecs[i].rd));
      chk({vecs[i].name, ".pc"},      out_pc,           32'h1000 + 32'(i) * 4);
      if (!vecs[i].illegal) begin
        chk({vecs[i].name, ".lhs_pc"},  32'(out_lhs_pc),  32'(vecs[i].lhs_pc));
        chk({vecs[i].name, ".rhs_imm"}, 32'(out_rhs_imm), 32'(vecs[i].rhs_imm));
        chk({vecs[i].name, ".imm"},     out_imm,          vecs[i].imm);
      end
    end

    // Register fields of add x1,x2,x3 and the no-Zbb build on ANDN.
    issue(32'h003100B3, 32'h2000);
    chk("add.rs1", 32'(out_rs1), 32'd2);
    chk("add.rs2", 32'(out_rs2), 32'd3);
    issue(32'h403170B3, 32'h2004);
    chk("nozbb_andn.illegal", 32'(z_out_illegal), 32'd1);
    chk("nozbb_andn.op", 32'(z_out_alu_op), 32'd0);
    chk("nozbb_andn.rd_we", 32'(z_out_rd_we), 32'd0);
    chk("zbb_andn.illegal", 32'(out_illegal), 32'd0);

    // Pop without accept drains the slot.
    @(posedge clk); #1;
    chk("pop_empty.valid", 32'(out_valid), 32'd0);

    // Stall: accept add, then hold out_ready=0 with sub waiting for 3 cycles.
    @(negedge clk);
    in_valid = 1'b1; in_inst = 32'h003100B3; in_pc = 32'h3000; out_ready = 1'b0;
    @(posedge clk); #1;
    in_inst = 32'h40B50533; in_pc = 32'h3004;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("stall.in_ready", 32'(in_ready), 32'd0);
      chk("stall.valid", 32'(out_valid), 32'd1);
      chk("stall.op", 32'(out_alu_op), 32'd0);
      chk("stall.rd", 32'(out_rd), 32'd1);
      chk("stall.pc", out_pc, 32'h3000);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("unstall.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("unstall.op", 32'(out_alu_op), 32'd8);
    chk("unstall.pc", out_pc, 32'h3004);

    // Back-to-back stream at one per cycle.
    seq[0] = 32'h40335293; seq_op[0] = 4'hD;
    seq[1] = 32'h123450B7; seq_op[1] = 4'hA;
    seq[2] = 32'h0020E463; seq_op[2] = 4'h3;
    seq[3] = 32'h003100B3; seq_op[3] = 4'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_inst = seq[k]; in_pc = 32'h4000 + 32'(k) * 4;
      @(posedge clk); #1;
      chk("b2b.valid", 32'(out_valid), 32'd1);
      chk("b2b.op", 32'(out_alu_op), 32'(seq_op[k]));
      chk("b2b.pc", out_pc, 32'h4000 + 32'(k) * 4);
      chk("b2b.in_ready", 32'(in_ready), 32'd1);
    end

    // Flush while full with a new input offered: both dropped.
    @(negedge clk);
    out_ready = 1'b0; in_inst = 32'h40B50533; in_pc = 32'h5000; flush = 1'b1;
    @(posedge clk); #1;
    chk("flush.valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("flush.dropped", 32'(out_valid), 32'd0);

    // Reset mid-stream wins over a pending input.
    issue(32'h123450B7, 32'h6000);
    chk("pre_reset.valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    reset_n = 1'b0; in_valid = 1'b1; in_inst = 32'h40B50533; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("midreset.valid", 32'(out_valid), 32'd0);
    chk("midreset.op", 32'(out_alu_op), 32'd0);
    chk("midreset.pc", out_pc, 32'd0);
    chk("midreset.rd", 32'(out_rd), 32'd0);
    @(negedge clk);
    reset_n = 1'b1; in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
